// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared encodings for the single-cycle RV32I core.
// Holds the opcode, funct3 and funct7 constants, the ALU operation and
// write-back select enums, and the funct3-to-ALU-op mapping shared by
// the register and immediate instruction classes.
package rv32i_pkg;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   // ALU funct3
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   // Branch funct3
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Word-sized load/store funct3 (the only widths implemented)
   localparam logic [2:0] F3_LW = 3'b010;
   localparam logic [2:0] F3_SW = 3'b010;

   // funct7 values; only bit 30 distinguishes SUB/SRA from ADD/SRL
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND
   } alu_op_e;

   typedef enum logic [1:0] {
      WB_ALU,
      WB_MEM,
      WB_PC4
   } wb_sel_e;

   // Map funct3 (plus the instr[30] "alternate" bit) to an ALU operation.
   // Callers must pass alt=0 where instr[30] is immediate data.
   function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
      alu_op_e op;
      case (f3)
         F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:     op = ALU_SLL;
         F3_SLT:     op = ALU_SLT;
         F3_SLTU:    op = ALU_SLTU;
         F3_XOR:     op = ALU_XOR;
         F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:      op = ALU_OR;
         F3_AND:     op = ALU_AND;
         default:    op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/data_mem.sv
// data_mem: word-addressed data RAM. Combinational read, write on the
// rising edge. Contents survive core reset.
// Ports:
//   clk       - clock
//   we        - store enable (already qualified by reset in the core)
//   word_addr - byte address [31:2]; wraps modulo DMEM_WORDS
//   wdata     - store data
//   rdata     - combinational load data
module data_mem #(
   parameter int DMEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        we,
   input  logic [29:0] word_addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata
);

   localparam int AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

   logic [31:0]   mem [0:DMEM_WORDS-1];
   logic [29:0]   word_mod_s;
   logic [AW-1:0] idx_s;

   assign word_mod_s = word_addr % 30'(DMEM_WORDS);
   assign idx_s      = word_mod_s[AW-1:0];
   assign rdata      = mem[idx_s];

   // Store port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx_s] <= wdata;
      end
   end

endmodule

// File: rtl/instr_mem.sv
// instr_mem: read-only instruction store, loaded hierarchically through
// `memory` by the environment. No reset, no write port.
// Ports:
//   word_addr - PC word address (pc[31:2]); wraps modulo IMEM_WORDS
//   instr     - combinational instruction word
module instr_mem #(
   parameter int IMEM_WORDS = 256
) (
   input  logic [29:0] word_addr,
   output logic [31:0] instr
);

   localparam int AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

   reg [31:0] memory [0:IMEM_WORDS-1];

   logic [29:0]   word_mod_s;
   logic [AW-1:0] idx_s;

   // Wrap the fetch address into the array
   assign word_mod_s = word_addr % 30'(IMEM_WORDS);
   assign idx_s      = word_mod_s[AW-1:0];
   assign instr      = memory[idx_s];

endmodule

// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit integer register file, two combinational read
// ports and one write port. x0 reads as zero and ignores writes.
// Ports:
//   clk, reset       - clock, synchronous active-low reset (clears all regs)
//   we, waddr, wdata - write port, committed on the rising edge
//   raddr1/2, rdata1/2 - combinational read ports (pre-edge values)
module reg_file (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2
);

   logic [31:0] regs [0:31];

   // Register write with reset taking priority over any pending write
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= 32'd0;
         end
      end else if (we && (waddr != 5'd0)) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
   assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/top.sv
// top: single-cycle RV32I core. Fetch, decode, execute, memory access and
// write-back all complete within one clock; every rising edge with
// reset=1 commits one instruction. Unsupported encodings behave as NOPs.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-low reset: pc and registers to zero,
//           the in-flight instruction is discarded
module top
   import rv32i_pkg::*;
#(
   parameter int IMEM_WORDS = 256,
   parameter int DMEM_WORDS = 256
) (
   input logic clk,
   input logic reset
);

   logic [31:0] pc_r;
   logic [31:0] next_pc_s;
   logic [31:0] pc_plus4_s;
   logic [31:0] instr_s;

   logic [6:0]  opcode_s;
   logic [4:0]  rd_s, rs1_s, rs2_s;
   logic [2:0]  f3_s;
   logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;

   logic [31:0] rs1_data_s, rs2_data_s;
   logic [31:0] alu_a_s, alu_b_s, alu_res_s;
   alu_op_e     alu_op_s;
   wb_sel_e     wb_sel_s;
   logic        rd_we_s, mem_we_s;
   logic        is_branch_s, is_jal_s, is_jalr_s, br_cond_s;
   logic [31:0] rd_data_s, mem_rdata_s;

   instr_mem #(.IMEM_WORDS(IMEM_WORDS)) imem (
      .word_addr (pc_r[31:2]),
      .instr     (instr_s)
   );

   reg_file rf (
      .clk    (clk),
      .reset  (reset),
      .we     (rd_we_s),
      .waddr  (rd_s),
      .wdata  (rd_data_s),
      .raddr1 (rs1_s),
      .raddr2 (rs2_s),
      .rdata1 (rs1_data_s),
      .rdata2 (rs2_data_s)
   );

   // A store coinciding with reset is dropped here; the memory has no reset
   data_mem #(.DMEM_WORDS(DMEM_WORDS)) dmem (
      .clk       (clk),
      .we        (mem_we_s & reset),
      .word_addr (alu_res_s[31:2]),
      .wdata     (rs2_data_s),
      .rdata     (mem_rdata_s)
   );

   assign opcode_s   = instr_s[6:0];
   assign rd_s       = instr_s[11:7];
   assign f3_s       = instr_s[14:12];
   assign rs1_s      = instr_s[19:15];
   assign rs2_s      = instr_s[24:20];
   assign pc_plus4_s = pc_r + 32'd4;

   assign imm_i_s = {{20{instr_s[31]}}, instr_s[31:20]};
   assign imm_s_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
   assign imm_b_s = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
   assign imm_u_s = {instr_s[31:12], 12'd0};
   assign imm_j_s = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};

   // Decoder: operand selection and write enables per opcode
   always_comb begin
      alu_op_s    = ALU_ADD;
      alu_a_s     = rs1_data_s;
      alu_b_s     = imm_i_s;
      wb_sel_s    = WB_ALU;
      rd_we_s     = 1'b0;
      mem_we_s    = 1'b0;
      is_branch_s = 1'b0;
      is_jal_s    = 1'b0;
      is_jalr_s   = 1'b0;
      case (opcode_s)
         OP_LUI: begin
            alu_a_s = 32'd0;
            alu_b_s = imm_u_s;
            rd_we_s = 1'b1;
         end
         OP_AUIPC: begin
            alu_a_s = pc_r;
            alu_b_s = imm_u_s;
            rd_we_s = 1'b1;
         end
         OP_JAL: begin
            is_jal_s = 1'b1;
            rd_we_s  = 1'b1;
            wb_sel_s = WB_PC4;
         end
         OP_JALR: begin
            // ALU computes rs1 + immI from pre-edge rs1, so rd == rs1 is safe
            is_jalr_s = 1'b1;
            rd_we_s   = 1'b1;
            wb_sel_s  = WB_PC4;
         end
         OP_BRANCH: begin
            // funct3 010/011 are not branches and fall through as NOPs
            is_branch_s = (f3_s != 3'b010) && (f3_s != 3'b011);
         end
         OP_LOAD: begin
            if (f3_s == F3_LW) begin
               rd_we_s  = 1'b1;
               wb_sel_s = WB_MEM;
            end else begin
               rd_we_s  = 1'b0;
            end
         end
         OP_STORE: begin
            alu_b_s = imm_s_s;
            if (f3_s == F3_SW) begin
               mem_we_s = 1'b1;
            end else begin
               mem_we_s = 1'b0;
            end
         end
         OP_IMM: begin
            // instr[30] is part of the immediate except for SRAI/SRLI
            alu_op_s = alu_op_from_f3(f3_s, (f3_s == F3_SRL_SRA) ? instr_s[30] : 1'b0);
            rd_we_s  = 1'b1;
         end
         OP_REG: begin
            alu_b_s  = rs2_data_s;
            alu_op_s = alu_op_from_f3(f3_s, instr_s[30]);
            rd_we_s  = 1'b1;
         end
         default: begin
            rd_we_s = 1'b0;
         end
      endcase
   end

   // ALU
   always_comb begin
      case (alu_op_s)
         ALU_ADD:  alu_res_s = alu_a_s + alu_b_s;
         ALU_SUB:  alu_res_s = alu_a_s - alu_b_s;
         ALU_SLL:  alu_res_s = alu_a_s << alu_b_s[4:0];
         ALU_SLT:  alu_res_s = {31'd0, $signed(alu_a_s) < $signed(alu_b_s)};
         ALU_SLTU: alu_res_s = {31'd0, alu_a_s < alu_b_s};
         ALU_XOR:  alu_res_s = alu_a_s ^ alu_b_s;
         ALU_SRL:  alu_res_s = alu_a_s >> alu_b_s[4:0];
         ALU_SRA:  alu_res_s = $unsigned($signed(alu_a_s) >>> alu_b_s[4:0]);
         ALU_OR:   alu_res_s = alu_a_s | alu_b_s;
         ALU_AND:  alu_res_s = alu_a_s & alu_b_s;
         default:  alu_res_s = 32'd0;
      endcase
   end

   // Branch condition on the two source registers
   always_comb begin
      case (f3_s)
         F3_BEQ:  br_cond_s = (rs1_data_s == rs2_data_s);
         F3_BNE:  br_cond_s = (rs1_data_s != rs2_data_s);
         F3_BLT:  br_cond_s = ($signed(rs1_data_s) < $signed(rs2_data_s));
         F3_BGE:  br_cond_s = ($signed(rs1_data_s) >= $signed(rs2_data_s));
         F3_BLTU: br_cond_s = (rs1_data_s < rs2_data_s);
         F3_BGEU: br_cond_s = (rs1_data_s >= rs2_data_s);
         default: br_cond_s = 1'b0;
      endcase
   end

   // Next-PC selection
   always_comb begin
      if (is_jal_s) begin
         next_pc_s = pc_r + imm_j_s;
      end else if (is_jalr_s) begin
         next_pc_s = alu_res_s & 32'hFFFF_FFFE;
      end else if (is_branch_s && br_cond_s) begin
         next_pc_s = pc_r + imm_b_s;
      end else begin
         next_pc_s = pc_plus4_s;
      end
   end

   // Write-back source selection
   always_comb begin
      case (wb_sel_s)
         WB_ALU:  rd_data_s = alu_res_s;
         WB_MEM:  rd_data_s = mem_rdata_s;
         WB_PC4:  rd_data_s = pc_plus4_s;
         default: rd_data_s = 32'd0;
      endcase
   end

   // Program counter register
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_r <= 32'd0;
      end else begin
         pc_r <= next_pc_s;
      end
   end

endmodule

// File: tb/tb_top.sv
// tb_top: directed-program bench for the single-cycle RV32I core.
// Programs are written into dut.imem.memory while reset is low; state is
// sampled on the falling clock edge through hierarchical references.
module tb_top;

   logic clk;
   logic reset;

   int n_chk;
   int n_err;

   top #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
      .clk   (clk),
      .reset (reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Instruction encoders
   function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
   endfunction

   function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
      return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input int imm, input int rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
   endfunction

   // Assert reset and clear instruction memory; caller then loads a program
   task automatic begin_prog();
      reset = 1'b0;
      for (int i = 0; i < 256; i++) begin
         dut.imem.memory[i] = 32'd0;
      end
   endtask

   // Let one reset edge pass, then release reset at the falling edge
   task automatic release_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [31:0] acc;

   initial begin
      n_chk = 0;
      n_err = 0;
      reset = 1'b0;

      // ---------------- LUI sequence ----------------
      begin_prog();
      dut.imem.memory[0] = 32'h00045b37;
      dut.imem.memory[1] = 32'h0012b337;
      dut.imem.memory[2] = 32'h000ab3b7;
      dut.imem.memory[3] = 32'h00000013;
      release_reset();
      check("reset_pc", dut.pc_r, 32'h0);
      check("reset_x22", dut.rf.regs[22], 32'h0);
      step(1);
      check("lui_x22", dut.rf.regs[22], 32'h00045000);
      step(1);
      check("lui_x6", dut.rf.regs[6], 32'h0012b000);
      step(1);
      check("lui_x7", dut.rf.regs[7], 32'h000ab000);
      step(1);
      check("lui_pc", dut.pc_r, 32'h10);
      acc = 32'h0;
      for (int i = 1; i < 32; i++) begin
         if (i != 6 && i != 7 && i != 22) acc = acc | dut.rf.regs[i];
      end
      check("lui_others_zero", acc, 32'h0);

      // ---------------- ALU ----------------
      begin_prog();
      dut.imem.memory[0]  = enc_i(-5, 0, 0, 1, 7'h13);        // addi x1,x0,-5
      dut.imem.memory[1]  = enc_i(3, 0, 0, 2, 7'h13);         // addi x2,x0,3
      dut.imem.memory[2]  = enc_r(0, 2, 1, 0, 3);             // add  x3
      dut.imem.memory[3]  = enc_r(32, 2, 1, 0, 4);            // sub  x4
      dut.imem.memory[4]  = enc_r(0, 2, 1, 2, 5);             // slt  x5
      dut.imem.memory[5]  = enc_r(0, 2, 1, 3, 6);             // sltu x6
      dut.imem.memory[6]  = enc_r(32, 2, 1, 5, 7);            // sra  x7
      dut.imem.memory[7]  = enc_i(7, 0, 0, 0, 7'h13);         // addi x0,x0,7
      dut.imem.memory[8]  = enc_r(0, 2, 1, 5, 8);             // srl  x8
      dut.imem.memory[9]  = enc_i(255, 1, 4, 9, 7'h13);       // xori x9,x1,0xff
      dut.imem.memory[10] = enc_i(31, 2, 1, 10, 7'h13);       // slli x10,x2,31
      dut.imem.memory[11] = enc_i(33, 0, 0, 12, 7'h13);       // addi x12,x0,33
      dut.imem.memory[12] = enc_r(0, 12, 2, 1, 11);           // sll  x11,x2,x12
      dut.imem.memory[13] = enc_i(32'h401, 1, 5, 13, 7'h13);  // srai x13,x1,1
      dut.imem.memory[14] = enc_i(-1, 2, 3, 14, 7'h13);       // sltiu x14,x2,-1
      dut.imem.memory[15] = enc_i(-4, 1, 2, 15, 7'h13);       // slti x15,x1,-4
      dut.imem.memory[16] = enc_r(0, 2, 1, 7, 16);            // and  x16
      dut.imem.memory[17] = enc_r(0, 2, 1, 6, 17);            // or   x17
      dut.imem.memory[18] = {20'h00001, 5'd18, 7'b0010111};   // auipc x18,1
      release_reset();
      step(19);
      check("alu_add", dut.rf.regs[3], 32'hFFFFFFFE);
      check("alu_sub", dut.rf.regs[4], 32'hFFFFFFF8);
      check("alu_slt", dut.rf.regs[5], 32'h1);
      check("alu_sltu", dut.rf.regs[6], 32'h0);
      check("alu_sra", dut.rf.regs[7], 32'hFFFFFFFF);
      check("alu_x0", dut.rf.regs[0], 32'h0);
      check("alu_srl", dut.rf.regs[8], 32'h1FFFFFFF);
      check("alu_xori", dut.rf.regs[9], 32'hFFFFFF04);
      check("alu_slli31", dut.rf.regs[10], 32'h80000000);
      check("alu_sll_amt5", dut.rf.regs[11], 32'h6);
      check("alu_srai", dut.rf.regs[13], 32'hFFFFFFFD);
      check("alu_sltiu", dut.rf.regs[14], 32'h1);
      check("alu_slti", dut.rf.regs[15], 32'h1);
      check("alu_and", dut.rf.regs[16], 32'h3);
      check("alu_or", dut.rf.regs[17], 32'hFFFFFFFB);
      check("alu_auipc", dut.rf.regs[18], 32'h00001048);
      check("alu_pc", dut.pc_r, 32'h4C);

      // ---------------- Memory ----------------
      begin_prog();
      dut.imem.memory[0] = enc_i(32'h40, 0, 0, 1, 7'h13);     // addi x1,x0,0x40
      dut.imem.memory[1] = enc_i(32'h123, 0, 0, 2, 7'h13);    // addi x2,x0,0x123
      dut.imem.memory[2] = enc_s(4, 2, 1, 2);                 // sw x2,4(x1)
      dut.imem.memory[3] = enc_i(4, 1, 2, 3, 7'h03);          // lw x3,4(x1)
      dut.imem.memory[4] = enc_s(4, 0, 1, 0);                 // sb x0,4(x1) -> NOP
      dut.imem.memory[5] = enc_i(4, 1, 0, 4, 7'h03);          // lb x4,4(x1) -> NOP
      dut.imem.memory[6] = enc_i(6, 1, 2, 5, 7'h03);          // lw x5,6(x1)
      dut.imem.memory[7] = 32'h00000000;
      dut.imem.memory[8] = 32'hFFFFFFFF;
      release_reset();
      step(3);
      check("mem_sw", dut.dmem.mem[17], 32'h123);
      step(1);
      check("mem_lw", dut.rf.regs[3], 32'h123);
      step(5);
      check("mem_sb_nop", dut.dmem.mem[17], 32'h123);
      check("mem_lb_nop", dut.rf.regs[4], 32'h0);
      check("mem_lw_unaligned", dut.rf.regs[5], 32'h123);
      check("mem_unknown_keep_x3", dut.rf.regs[3], 32'h123);
      check("mem_unknown_pc", dut.pc_r, 32'h24);

      // ---------------- Control flow ----------------
      begin_prog();
      dut.imem.memory[0]  = enc_i(1, 0, 0, 5, 7'h13);         // addi x5,x0,1
      dut.imem.memory[1]  = enc_i(1, 0, 0, 6, 7'h13);         // addi x6,x0,1
      dut.imem.memory[2]  = enc_b(8, 6, 5, 0);                // beq x5,x6,+8
      dut.imem.memory[3]  = enc_i(99, 0, 0, 7, 7'h13);        // skipped
      dut.imem.memory[4]  = enc_b(8, 6, 5, 1);                // bne not taken
      dut.imem.memory[5]  = enc_i(2, 0, 0, 8, 7'h13);         // addi x8,x0,2
      dut.imem.memory[6]  = enc_b(8, 5, 0, 4);                // blt x0,x5,+8
      dut.imem.memory[7]  = enc_i(98, 0, 0, 7, 7'h13);        // skipped
      dut.imem.memory[8]  = enc_j(8, 1);                      // jal x1,+8
      dut.imem.memory[9]  = enc_i(3, 0, 0, 9, 7'h13);         // addi x9,x0,3
      dut.imem.memory[10] = enc_i(1, 1, 0, 1, 7'h67);         // jalr x1,1(x1)
      dut.imem.memory[11] = enc_b(-44, 0, 5, 7);              // bgeu x5,x0,-44
      release_reset();
      step(3);
      check("cf_beq_taken_pc", dut.pc_r, 32'h10);
      step(1);
      check("cf_bne_fall_pc", dut.pc_r, 32'h14);
      step(3);
      check("cf_jal_pc", dut.pc_r, 32'h28);
      check("cf_jal_link", dut.rf.regs[1], 32'h24);
      step(1);
      check("cf_jalr_pc", dut.pc_r, 32'h24);
      check("cf_jalr_link_rd_eq_rs1", dut.rf.regs[1], 32'h2C);
      step(3);
      check("cf_bgeu_back_pc", dut.pc_r, 32'h0);
      check("cf_skipped_x7", dut.rf.regs[7], 32'h0);
      check("cf_fall_x8", dut.rf.regs[8], 32'h2);
      check("cf_ret_x9", dut.rf.regs[9], 32'h3);

      // ---------------- Reset mid-run ----------------
      begin_prog();
      dut.imem.memory[0] = enc_i(32'h40, 0, 0, 1, 7'h13);     // addi x1,x0,0x40
      dut.imem.memory[1] = enc_i(32'h55, 0, 0, 2, 7'h13);     // addi x2,x0,0x55
      dut.imem.memory[2] = enc_i(1, 0, 0, 3, 7'h13);
      dut.imem.memory[3] = enc_i(2, 0, 0, 4, 7'h13);
      dut.imem.memory[4] = enc_i(3, 0, 0, 5, 7'h13);
      dut.imem.memory[5] = enc_s(4, 2, 1, 2);                 // sw x2,4(x1)
      release_reset();
      step(5);
      check("rst_pre_x5", dut.rf.regs[5], 32'h3);
      reset = 1'b0;
      step(1);
      check("rst_pc", dut.pc_r, 32'h0);
      acc = 32'h0;
      for (int i = 0; i < 32; i++) acc = acc | dut.rf.regs[i];
      check("rst_regs_zero", acc, 32'h0);
      check("rst_store_dropped", dut.dmem.mem[17], 32'h123);
      reset = 1'b1;
      step(1);
      check("rst_rerun_x1", dut.rf.regs[1], 32'h40);
      check("rst_rerun_pc", dut.pc_r, 32'h4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
